// File: rtl/debounce_chan.sv
// rtl/debounce_chan.sv - one button channel: synchroniser, stable-time debounce, edge and long-press pulses
module debounce_chan #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int ACTIVE_LOW  = 1,
  parameter int HOLD_W      = 8,
  parameter int HOLD_TICKS  = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  input  logic tick,
  output logic clean,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("debounce_chan: SYNC_STAGES must be 2..4");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("debounce_chan: CNT_W must be at least 1");
  end
  if (HOLD_W < 1 || HOLD_W > 30) begin : g_bad_hold_w
    $error("debounce_chan: HOLD_W must be 1..30");
  end
  if (HOLD_TICKS < 1 || HOLD_TICKS > (1 << HOLD_W) - 1) begin : g_bad_hold_ticks
    $error("debounce_chan: HOLD_TICKS must be 1..2^HOLD_W-1");
  end

  localparam logic              IDLE_LVL = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic                   clean_q, clean_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   long_q, long_d;
  logic                   pressed_s;

  assign pressed_s = sync_q[SYNC_STAGES-1] ^ IDLE_LVL;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], raw_in};
    cnt_d     = cnt_q;
    clean_d   = clean_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (pressed_s == clean_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d     = '0;
      clean_d   = ~clean_q;
      press_d   = ~clean_q;
      release_d = clean_q;
    end
  end

  // Hold tracks the next clean level so a release edge that coincides with a tick cannot fire long_pulse.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (!clean_d) begin
      hold_d = '0;
    end else if (tick && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + 1'b1;
      long_d = (hold_d == HOLD_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= {SYNC_STAGES{IDLE_LVL}};
      cnt_q     <= '0;
      hold_q    <= '0;
      clean_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      clean_q   <= clean_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign clean         = clean_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;

endmodule

// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - multi-channel push-button conditioner with a shared long-press tick generator
module debounce_bank #(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int ACTIVE_LOW  = 1,
  parameter int HOLD_W      = 8,
  parameter int HOLD_TICKS  = 200
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] long_pulse
);

  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
    $error("debounce_bank: CHANNELS must be 1..32");
  end

  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick;

  // One tick per debounce period, shared by every channel's hold counter.
  always_comb begin
    tick_cnt_d = tick_cnt_q + 1'b1;
  end

  assign tick = &tick_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debounce_chan #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES),
      .ACTIVE_LOW  (ACTIVE_LOW),
      .HOLD_W      (HOLD_W),
      .HOLD_TICKS  (HOLD_TICKS)
    ) u_chan (
      .clk           (clk),
      .rst_n         (rst_n),
      .raw_in        (raw_in[i]),
      .tick          (tick),
      .clean         (clean[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .long_pulse    (long_pulse[i])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// tb/tb_debounce_bank.sv - self-checking bench for debounce_bank
module tb_debounce_bank;
  localparam int CH   = 2;
  localparam int CW   = 4;
  localparam int SS   = 2;
  localparam int HW   = 4;
  localparam int HT   = 3;
  localparam int AL   = 1;
  localparam int TICK = 1 << CW;
  localparam int LAT  = SS + TICK;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] raw_in = 2'b11;
  logic [CH-1:0] clean, press_pulse, release_pulse, long_pulse;

  int edge_no = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    int ch;
    int kind;
    int lo;
    int hi;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0] raw;
    int         hold;
    logic [1:0] p;
    logic [1:0] r;
    logic [1:0] l;
    logic [1:0] clean_end;
  } vec_t;
  vec_t vecs[11];

  debounce_bank #(
    .CHANNELS    (CH),
    .CNT_W       (CW),
    .SYNC_STAGES (SS),
    .ACTIVE_LOW  (AL),
    .HOLD_W      (HW),
    .HOLD_TICKS  (HT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .raw_in        (raw_in),
    .clean         (clean),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_no <= edge_no + 1;

  function automatic logic pulse_of(int kind, int ch);
    case (kind)
      0:       return press_pulse[ch];
      1:       return release_pulse[ch];
      default: return long_pulse[ch];
    endcase
  endfunction

  function automatic string kind_name(int kind);
    case (kind)
      0:       return "press";
      1:       return "release";
      default: return "long";
    endcase
  endfunction

  task automatic push_exp(int ch, int kind, int lo, int hi);
    exp_t e;
    e.ch = ch; e.kind = kind; e.lo = lo; e.hi = hi;
    sb.push_back(e);
  endtask

  task automatic wait_edges(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk2(string name, logic [1:0] got, logic [1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b required %b", name, got, want);
    end
  endtask

  // Drive a raw level and queue the pulses it must cause, timed from the drive edge.
  task automatic apply(logic [1:0] raw, logic [1:0] p, logic [1:0] r, logic [1:0] l);
    int t;
    raw_in = raw;
    t = edge_no;
    for (int c = 0; c < CH; c++) begin
      if (p[c]) push_exp(c, 0, t + LAT, t + LAT);
      if (r[c]) push_exp(c, 1, t + LAT, t + LAT);
      if (l[c]) push_exp(c, 2, t + LAT + (HT - 1) * TICK, t + LAT + HT * TICK);
    end
  endtask

  int idx;
  always @(negedge clk) begin
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (pulse_of(k, c)) begin
          idx = -1;
          for (int i = 0; i < sb.size(); i++) begin
            if (idx < 0 && sb[i].ch == c && sb[i].kind == k) idx = i;
          end
          total++;
          if (idx < 0) begin
            bad++;
            $display("FAIL unexpected_%s ch%0d: pulse at edge %0d, none required", kind_name(k), c, edge_no);
          end else begin
            if (edge_no < sb[idx].lo || edge_no > sb[idx].hi) begin
              bad++;
              $display("FAIL %s_time ch%0d: got edge %0d required %0d..%0d",
                       kind_name(k), c, edge_no, sb[idx].lo, sb[idx].hi);
            end
            sb.delete(idx);
          end
        end
      end
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].hi < edge_no) begin
        total++;
        bad++;
        $display("FAIL missing_%s ch%0d: no pulse by edge %0d required %0d..%0d",
                 kind_name(sb[i].kind), sb[i].ch, edge_no, sb[i].lo, sb[i].hi);
        sb.delete(i);
      end
    end
  end

  initial begin
    vecs[0]  = '{2'b11, 100, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[1]  = '{2'b10, 30,  2'b01, 2'b00, 2'b00, 2'b01};
    vecs[2]  = '{2'b11, 30,  2'b00, 2'b01, 2'b00, 2'b00};
    vecs[3]  = '{2'b10, 80,  2'b01, 2'b00, 2'b01, 2'b01};
    vecs[4]  = '{2'b11, 30,  2'b00, 2'b01, 2'b00, 2'b00};
    vecs[5]  = '{2'b10, 80,  2'b01, 2'b00, 2'b01, 2'b01};
    vecs[6]  = '{2'b11, 30,  2'b00, 2'b01, 2'b00, 2'b00};
    vecs[7]  = '{2'b00, 30,  2'b11, 2'b00, 2'b00, 2'b11};
    vecs[8]  = '{2'b11, 30,  2'b00, 2'b11, 2'b00, 2'b00};
    vecs[9]  = '{2'b01, 30,  2'b10, 2'b00, 2'b00, 2'b10};
    vecs[10] = '{2'b11, 30,  2'b00, 2'b10, 2'b00, 2'b00};

    rst_n  = 1'b0;
    raw_in = 2'b11;
    wait_edges(3);
    chk2("reset_clean", clean, 2'b00);
    chk2("reset_press", press_pulse, 2'b00);
    chk2("reset_release", release_pulse, 2'b00);
    chk2("reset_long", long_pulse, 2'b00);
    rst_n = 1'b1;

    for (int v = 0; v < 11; v++) begin
      apply(vecs[v].raw, vecs[v].p, vecs[v].r, vecs[v].l);
      wait_edges(vecs[v].hold);
      chk2($sformatf("vec%0d_clean", v), clean, vecs[v].clean_end);
    end

    // Bounce: only the final low that is held long enough may produce a press.
    raw_in = 2'b10; wait_edges(10);
    raw_in = 2'b11; wait_edges(3);
    raw_in = 2'b10; wait_edges(12);
    chk2("bounce_mid_clean", clean, 2'b00);
    raw_in = 2'b11; wait_edges(2);
    apply(2'b10, 2'b01, 2'b00, 2'b00);
    wait_edges(LAT - 1);
    chk2("bounce_before_clean", clean, 2'b00);
    wait_edges(12);
    chk2("bounce_clean", clean, 2'b01);
    apply(2'b11, 2'b00, 2'b01, 2'b00);
    wait_edges(30);
    chk2("bounce_release_clean", clean, 2'b00);

    // Async reset while channel 1 is pressed and channel 0 is mid-count.
    apply(2'b01, 2'b10, 2'b00, 2'b00);
    wait_edges(30);
    chk2("pre_reset_clean", clean, 2'b10);
    raw_in = 2'b00;
    wait_edges(10);
    #1 rst_n = 1'b0;
    #1;
    chk2("async_reset_clean", clean, 2'b00);
    chk2("async_reset_pulses", press_pulse | release_pulse | long_pulse, 2'b00);
    sb.delete();
    wait_edges(3);
    rst_n = 1'b1;
    apply(2'b00, 2'b11, 2'b00, 2'b00);
    wait_edges(LAT - 1);
    chk2("post_reset_early_clean", clean, 2'b00);
    wait_edges(12);
    chk2("post_reset_clean", clean, 2'b11);
    apply(2'b11, 2'b00, 2'b11, 2'b00);
    wait_edges(30);
    chk2("final_clean", clean, 2'b00);

    wait_edges(5);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL leftover_expectations: got %0d pending required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
